// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte/address widths, invalid address,
// and the router_fsm state encodings also used by the testbenches.
package router_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 2;

    typedef logic [DATA_WIDTH-1:0] rbyte_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_INVALID = 2'b11;

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] LOAD_PARITY        = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd6;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

endpackage

// File: rtl/router_reg_if.sv
// Bundle between router_fsm/source and router_reg: byte stream, FSM state
// decodes and status returns. err_count exists only with ROUTER_REG_ERR_CNT_EN.
interface router_reg_if;
    import router_pkg::*;

    logic   pkt_valid;
    rbyte_t data_in;
    logic   fifo_full;
    logic   detect_add;
    logic   lfd_state;
    logic   ld_state;
    logic   laf_state;
    logic   full_state;
    logic   rst_int_reg;
    logic   parity_done;
    logic   low_pkt_valid;
    logic   err;
    rbyte_t dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    modport master (
`ifdef ROUTER_REG_ERR_CNT_EN
        input  err_count,
`endif
        output pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        input  parity_done, low_pkt_valid, err, dout
    );

    modport slave (
`ifdef ROUTER_REG_ERR_CNT_EN
        output err_count,
`endif
        input  pkt_valid, data_in, fifo_full, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg,
        output parity_done, low_pkt_valid, err, dout
    );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes; clear beats header load beats
// payload accumulate, so the parity byte itself is never folded in.
module router_parity_acc
    import router_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  logic   clear_i,
    input  logic   lfd_i,
    input  logic   acc_en_i,
    input  rbyte_t header_i,
    input  rbyte_t data_i,
    output rbyte_t parity_o
);

    rbyte_t parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (clear_i) begin
            parity_d = '0;
        end else if (lfd_i) begin
            parity_d = parity_q ^ header_i;
        end else if (acc_en_i) begin
            parity_d = parity_q ^ data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity_o = parity_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/full/parity capture, FIFO write byte,
// parity check. Optional err_count output under ROUTER_REG_ERR_CNT_EN.
module router_reg
    import router_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    router_reg_if.slave  bus
);

    rbyte_t header_q, header_d;
    rbyte_t full_byte_q, full_byte_d;
    rbyte_t dout_q, dout_d;
    rbyte_t pkt_parity_q, pkt_parity_d;
    rbyte_t int_parity;
    logic   low_pkt_valid_q, low_pkt_valid_d;
    logic   parity_done_q, parity_done_d;
    logic   err_q, err_d;

    router_parity_acc u_parity_acc (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (bus.detect_add),
        .lfd_i    (bus.lfd_state),
        .acc_en_i (bus.ld_state && bus.pkt_valid && !bus.full_state),
        .header_i (header_q),
        .data_i   (bus.data_in),
        .parity_o (int_parity)
    );

    always_comb begin
        header_d        = header_q;
        full_byte_d     = full_byte_q;
        dout_d          = dout_q;
        pkt_parity_d    = pkt_parity_q;
        low_pkt_valid_d = low_pkt_valid_q;
        parity_done_d   = parity_done_q;
        err_d           = err_q;

        if (bus.detect_add && bus.pkt_valid &&
            bus.data_in[ADDR_WIDTH-1:0] != ADDR_INVALID) begin
            header_d = bus.data_in;
        end
        if (bus.ld_state && bus.fifo_full) begin
            full_byte_d = bus.data_in;
        end

        if (bus.lfd_state) begin
            dout_d = header_q;
        end else if (bus.ld_state && !bus.fifo_full) begin
            dout_d = bus.data_in;
        end else if (bus.laf_state) begin
            dout_d = full_byte_q;
        end

        if (bus.detect_add) begin
            pkt_parity_d = '0;
        end else if (bus.ld_state && !bus.pkt_valid) begin
            pkt_parity_d = bus.data_in;
        end

        if (bus.rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (bus.ld_state && !bus.pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end

        // Second term completes a packet whose parity byte met a full FIFO.
        if (bus.detect_add) begin
            parity_done_d = 1'b0;
        end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                     (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
            parity_done_d = 1'b1;
        end

        if (bus.detect_add) begin
            err_d = 1'b0;
        end else if (parity_done_q) begin
            err_d = (int_parity != pkt_parity_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            header_q        <= '0;
            full_byte_q     <= '0;
            dout_q          <= '0;
            pkt_parity_q    <= '0;
            low_pkt_valid_q <= 1'b0;
            parity_done_q   <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            header_q        <= header_d;
            full_byte_q     <= full_byte_d;
            dout_q          <= dout_d;
            pkt_parity_q    <= pkt_parity_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            parity_done_q   <= parity_done_d;
            err_q           <= err_d;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && !err_q && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Table-driven bench for router_reg; expected outputs are queued as each
// vector is driven and popped after the clock edge.
module tb_router_reg;
    import router_pkg::*;

    typedef struct {
        logic       rstn;
        logic [2:0] st;
        logic       pv;
        logic [7:0] d;
        logic       ff;
        logic [7:0] dout;
        logic       pd;
        logic       lpv;
        logic       err;
    } vec_t;

    localparam logic [2:0] DA = DECODE_ADDRESS;
    localparam logic [2:0] LF = LOAD_FIRST_DATA;
    localparam logic [2:0] LD = LOAD_DATA;
    localparam logic [2:0] FS = FIFO_FULL_STATE;
    localparam logic [2:0] LA = LOAD_AFTER_FULL;
    localparam logic [2:0] CK = CHECK_PARITY_ERROR;
    localparam logic [2:0] ID = WAIT_TILL_EMPTY;

    logic clk;
    logic resetn;
    router_reg_if rif ();

    router_reg dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned step_no  = 0;
    vec_t        tbl[$];
    vec_t        sb[$];
    int unsigned exp_cnt  = 0;
    logic        prev_err = 1'b0;

    function automatic vec_t V(input logic r, input logic [2:0] s, input logic p,
                               input logic [7:0] d, input logic f, input logic [7:0] o,
                               input logic pd, input logic lpv, input logic er);
        vec_t v;
        v.rstn = r; v.st = s; v.pv = p; v.d = d; v.ff = f;
        v.dout = o; v.pd = pd; v.lpv = lpv; v.err = er;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL step %0d %s: got %h, expected %h", step_no, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        resetn          = v.rstn;
        rif.pkt_valid   = v.pv;
        rif.data_in     = v.d;
        rif.fifo_full   = v.ff;
        rif.detect_add  = (v.st == DA);
        rif.lfd_state   = (v.st == LF);
        rif.ld_state    = (v.st == LD);
        rif.laf_state   = (v.st == LA);
        rif.full_state  = (v.st == FS);
        rif.rst_int_reg = (v.st == CK);
        sb.push_back(v);
        if (!v.rstn) begin
            exp_cnt  = 0;
            prev_err = 1'b0;
        end else begin
            if (v.err && !prev_err && exp_cnt != 255) exp_cnt++;
            prev_err = v.err;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("dout",          rif.dout,                 e.dout);
        check("parity_done",   {7'd0, rif.parity_done},  {7'd0, e.pd});
        check("low_pkt_valid", {7'd0, rif.low_pkt_valid}, {7'd0, e.lpv});
        check("err",           {7'd0, rif.err},          {7'd0, e.err});
`ifdef ROUTER_REG_ERR_CNT_EN
        check("err_count",     rif.err_count,            exp_cnt[7:0]);
`endif
        step_no++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        rif.pkt_valid = 1'b0; rif.data_in = '0; rif.fifo_full = 1'b0;
        rif.detect_add = 1'b0; rif.lfd_state = 1'b0; rif.ld_state = 1'b0;
        rif.laf_state = 1'b0; rif.full_state = 1'b0; rif.rst_int_reg = 1'b0;

        // reset
        tbl.push_back(V(0, ID, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
        // good packet 0D 11 22 33, parity 0D
        tbl.push_back(V(1, DA, 1, 8'h0D, 0, 8'h00, 0, 0, 0));
        tbl.push_back(V(1, LF, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        tbl.push_back(V(1, LD, 0, 8'h0D, 0, 8'h0D, 1, 1, 0));
        tbl.push_back(V(1, CK, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
        tbl.push_back(V(1, ID, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
        // same packet, bad parity 00
        tbl.push_back(V(1, DA, 1, 8'h0D, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(V(1, LF, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h22, 0, 8'h22, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        tbl.push_back(V(1, LD, 0, 8'h00, 0, 8'h00, 1, 1, 0));
        tbl.push_back(V(1, CK, 0, 8'h00, 0, 8'h00, 1, 0, 1));
        tbl.push_back(V(1, ID, 0, 8'h00, 0, 8'h00, 1, 0, 1));
        tbl.push_back(V(1, DA, 1, 8'h0D, 0, 8'h00, 0, 0, 0));
        // fifo_full on payload 22
        tbl.push_back(V(1, LF, 1, 8'h11, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h11, 0, 8'h11, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h22, 1, 8'h11, 0, 0, 0));
        tbl.push_back(V(1, FS, 1, 8'h22, 1, 8'h11, 0, 0, 0));
        tbl.push_back(V(1, LA, 1, 8'h33, 0, 8'h22, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h33, 0, 8'h33, 0, 0, 0));
        tbl.push_back(V(1, LD, 0, 8'h0D, 0, 8'h0D, 1, 1, 0));
        tbl.push_back(V(1, CK, 0, 8'h00, 0, 8'h0D, 1, 0, 0));
        // invalid address keeps old header; early drop with full FIFO on parity
        tbl.push_back(V(1, DA, 1, 8'h07, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(V(1, LF, 1, 8'hA5, 0, 8'h0D, 0, 0, 0));
        tbl.push_back(V(1, LD, 0, 8'hA5, 1, 8'h0D, 0, 1, 0));
        tbl.push_back(V(1, FS, 0, 8'h00, 1, 8'h0D, 0, 1, 0));
        tbl.push_back(V(1, LA, 0, 8'h00, 0, 8'hA5, 1, 1, 0));
        tbl.push_back(V(1, CK, 0, 8'h00, 0, 8'hA5, 1, 0, 1));
        tbl.push_back(V(1, ID, 0, 8'h00, 0, 8'hA5, 1, 0, 1));
        // reset mid-packet, then clean packet 05 10, parity 15
        tbl.push_back(V(1, DA, 1, 8'h05, 0, 8'hA5, 0, 0, 0));
        tbl.push_back(V(1, LF, 1, 8'h5A, 0, 8'h05, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h5A, 0, 8'h5A, 0, 0, 0));
        tbl.push_back(V(0, LD, 0, 8'h77, 0, 8'h00, 0, 0, 0));
        tbl.push_back(V(1, DA, 1, 8'h05, 0, 8'h00, 0, 0, 0));
        tbl.push_back(V(1, LF, 1, 8'h10, 0, 8'h05, 0, 0, 0));
        tbl.push_back(V(1, LD, 1, 8'h10, 0, 8'h10, 0, 0, 0));
        tbl.push_back(V(1, LD, 0, 8'h15, 0, 8'h15, 1, 1, 0));
        tbl.push_back(V(1, CK, 0, 8'h00, 0, 8'h15, 1, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // header register must be cleared by reset: LFD without decode gives 00
        apply(V(0, ID, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        apply(V(1, LF, 1, 8'h00, 0, 8'h00, 0, 0, 0));

        // repeated bad-parity packets; error counter saturates when present
        for (int i = 0; i < 258; i++) begin
            apply(V(1, DA, 1, 8'h0D, 0, 8'h00, 0, 0, 0));
            apply(V(1, LF, 1, 8'h00, 0, 8'h0D, 0, 0, 0));
            apply(V(1, LD, 0, 8'h00, 0, 8'h00, 1, 1, 0));
            apply(V(1, CK, 0, 8'h00, 0, 8'h00, 1, 0, 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router.
- Sits directly downstream of router_fsm and consumes its state decodes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Captures header, payload and parity bytes, drives the byte written into the selected output FIFO, and accumulates internal parity.
- Returns parity_done and low_pkt_valid to router_fsm and raises err on a parity mismatch.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/dout.
- ADDR_WIDTH, 2, width of the destination field in data_in[ADDR_WIDTH-1:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous, active-low reset.
- pkt_valid  input  1  source asserts while header/payload bytes are on data_in; deasserts for the parity byte.
- data_in  input  DATA_WIDTH  packet byte stream.
- fifo_full  input  1  full flag of the currently addressed FIFO.
- detect_add  input  1  FSM in DECODE_ADDRESS.
- lfd_state  input  1  FSM in LOAD_FIRST_DATA.
- ld_state  input  1  FSM in LOAD_DATA.
- laf_state  input  1  FSM in LOAD_AFTER_FULL.
- full_state  input  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR; clears low_pkt_valid.
- parity_done  output  1  parity byte captured; packet complete.
- low_pkt_valid  output  1  pkt_valid fell while loading.
- err  output  1  internal parity != packet parity.
- dout  output  DATA_WIDTH  byte to FIFO write port.

Behaviour:
- Reset (resetn=0 at a clk edge): dout, header_byte, full_byte, int_parity, pkt_parity = 0; parity_done, low_pkt_valid, err = 0. Reset has priority over every other condition, including mid-packet.
- Internal registers:
  - header_byte: when detect_add && pkt_valid && data_in[1:0]!=2'b11, load data_in.
  - full_byte: when ld_state && fifo_full, load data_in (the byte that could not be written).
- dout priority, high to low:
  - lfd_state: dout <= header_byte.
  - ld_state && !fifo_full: dout <= data_in.
  - laf_state: dout <= full_byte.
  - otherwise: hold.
- int_parity priority:
  - detect_add: clear to 0.
  - lfd_state: int_parity ^= header_byte.
  - ld_state && pkt_valid && !full_state: int_parity ^= data_in.
  - otherwise: hold.
  - The parity byte itself is never accumulated.
- pkt_parity: detect_add clears it; ld_state && !pkt_valid loads data_in.
- low_pkt_valid: rst_int_reg clears it (priority); ld_state && !pkt_valid sets it; otherwise hold.
- parity_done:
  - detect_add clears it.
  - Sets on (ld_state && !fifo_full && !pkt_valid) || (laf_state && low_pkt_valid && !parity_done).
  - Otherwise hold.
- err:
  - detect_add clears it.
  - When parity_done==1, err <= (int_parity != pkt_parity).
  - Otherwise hold, so err stays visible until the next packet's decode.
- Latency:
  - Header appears on dout 1 cycle after lfd_state is sampled.
  - Payload appears 1 cycle after ld_state.
  - err is valid 1 cycle after parity_done rises.
- Boundary conditions:
  - Invalid address 2'b11: header_byte is not updated.
  - fifo_full asserted on the parity byte: pkt_parity still loads; parity_done sets later via the laf_state term.
  - Simultaneous detect_add and rst_int_reg cannot occur (one-hot FSM). If both are high, each register applies its own priority independently.

Optional Feature:
- Macro: ROUTER_REG_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0].
  - Increments once per packet on the cycle err transitions 0->1.
  - Saturates at 8'hFF.
  - Cleared only by resetn.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- router_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH.
  - ADDR_INVALID = 2'b11.
  - Shared FSM state encodings used by router_fsm and the testbenches.
- One sub-module, router_parity_acc: the int_parity accumulator with its clear/xor/hold priority, instantiated once.
- Everything else stays flat.

Test Plan:
- Reset: drive resetn=0 for 1 clk with data_in=8'hFF -> dout=0, parity_done=0, low_pkt_valid=0, err=0.
- Good packet, no full:
  - Stimulus: header 8'h0D (len 3, addr 01); payload 8'h11, 8'h22, 8'h33; parity 8'h0D^8'h11^8'h22^8'h33=8'h0D.
  - Response: dout sequence 0D,11,22,33; parity_done=1 one cycle after the parity byte; err=0.
- Bad parity: same packet with parity byte 8'h00 -> err=1 one cycle after parity_done; err clears on the next detect_add.
- fifo_full mid-payload:
  - Stimulus: fifo_full=1 while ld_state with data_in=8'h22, then laf_state.
  - Response: dout holds 8'h11, then drives 8'h22 in laf_state; int_parity still includes 8'h22 exactly once.
- Early pkt_valid drop:
  - Stimulus: pkt_valid=0 in ld_state with data_in=8'hA5.
  - Response: low_pkt_valid=1 and pkt_parity=8'hA5; low_pkt_valid=0 after the rst_int_reg cycle.
- Reset mid-packet: assert resetn=0 during ld_state -> all outputs 0 next edge; next header 8'h05 decodes cleanly. With ROUTER_REG_ERR_CNT_EN, err_count = number of bad-parity packets, saturating at 8'hFF.
